bcd_counter_4digit: RTL and testbench

Four-decade BCD up/down counter that produces the d0..d3 digit bus consumed by the alarm comparator and the 4-digit display driver. A parameterised prescaler derives the count step from the system clock. Supports load, pause and direction control, with wrap or saturate at the terminal counts. d0 is the least-significant decade.

---
 rtl/bcd_counter_4digit_pkg.sv | 50 +++++
 rtl/bcd_decade.sv | 50 +++++
 rtl/bcd_counter_4digit.sv | 120 ++++++++++++
 tb/tb_bcd_counter_4digit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_4digit_pkg.sv
// Shared definitions for the 4-digit BCD counter, alarm comparator and display driver.
// Digit values, bus ordering and small BCD arithmetic helpers.
package bcd_counter_4digit_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_MIN    = 4'd0;
    // Digit-bus ordering: index 0 is d0, the least-significant decade.
    localparam int         DIGIT_LSD  = 0;
    localparam int         DIGIT_MSD  = NUM_DIGITS - 1;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [0:0] {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic bcd_t bcd_clamp(input logic [3:0] nib);
        bcd_t r;
        if (nib > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = nib;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t d);
        bcd_t r;
        if (d >= BCD_MAX) begin
            r = BCD_MIN;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d);
        bcd_t r;
        if ((d == BCD_MIN) || (d > BCD_MAX)) begin
            r = BCD_MAX;
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: loadable up/down digit with combinational carry/borrow out.
module bcd_decade
    import bcd_counter_4digit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_nib,
    output logic [3:0] digit,
    output logic       step_out
);

    bcd_t digit_q;
    bcd_t digit_d;
    dir_e dir_s;

    assign dir_s = dir_e'(up);

    // Next digit value: load beats step, otherwise hold.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_nib);
        end else if (step_in) begin
            if (dir_s == DIR_UP) begin
                digit_d = bcd_inc(digit_q);
            end else begin
                digit_d = bcd_dec(digit_q);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit    = digit_q;
    assign step_out = step_in & ((dir_s == DIR_UP) ? (digit_q == BCD_MAX)
                                                   : (digit_q == BCD_MIN));

endmodule

// File: rtl/bcd_counter_4digit.sv
// Four-decade BCD up/down counter with prescaler, load, pause and wrap/saturate terminal handling.
module bcd_counter_4digit
    import bcd_counter_4digit_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int SATURATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic        tick,
    output logic        wrap,
    output logic        done
);

    localparam int            PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic          SAT_EN  = (SATURATE != 0);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    logic          step_due_s;
    logic          step_apply_s;
    logic          at_term_s;
    logic [NUM_DIGITS:0] step_chain_s;
    bcd_t          digit_s [NUM_DIGITS];

    assign step_due_s = en & (presc_q == PS_LAST);

    // Terminal count in the current direction: all decades at 9 (up) or all at 0 (down).
    always_comb begin
        at_term_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (up) begin
                at_term_s = at_term_s & (digit_s[i] == BCD_MAX);
            end else begin
                at_term_s = at_term_s & (digit_s[i] == BCD_MIN);
            end
        end
    end

    // In saturate mode a step attempted at the terminal count is swallowed.
    assign step_apply_s    = step_due_s & ~load & ~(SAT_EN & at_term_s);
    assign step_chain_s[0] = step_apply_s;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
        bcd_decade u_decade (
            .clk      (clk),
            .rst      (rst),
            .step_in  (step_chain_s[g]),
            .up       (up),
            .load     (load),
            .load_nib (load_val[g*DIGIT_W +: DIGIT_W]),
            .digit    (digit_s[g]),
            .step_out (step_chain_s[g+1])
        );
    end

    // Prescaler and status-flag next state.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (load) begin
            presc_d = '0;
            done_d  = 1'b0;
        end else if (en) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
            tick_d = step_due_s;
            wrap_d = ~SAT_EN & step_chain_s[NUM_DIGITS];
            if (SAT_EN & step_due_s & at_term_s) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler and pulse/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign d0   = digit_s[DIGIT_LSD];
    assign d1   = digit_s[DIGIT_LSD + 1];
    assign d2   = digit_s[DIGIT_LSD + 2];
    assign d3   = digit_s[DIGIT_MSD];
    assign tick = tick_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// Self-checking bench: a wrapping and a saturating counter driven in parallel and compared
// against an integer-valued reference model, plus directed tables and corner sequences.
module tb_bcd_counter_4digit;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [3:0]  w_d0, w_d1, w_d2, w_d3, s_d0, s_d1, s_d2, s_d3;
    logic        w_tick, w_wrap, w_done, s_tick, s_wrap, s_done;
    logic [15:0] w_bus, s_bus;

    int total = 0;
    int bad   = 0;

    // reference model: counts kept as plain integers 0..9999
    int m_ph, m_vw, m_vs;
    bit m_tick, m_wrapw, m_done;

    always #5 clk = ~clk;

    bcd_counter_4digit #(.TICK_DIV(TD), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .d0(w_d0), .d1(w_d1), .d2(w_d2), .d3(w_d3),
        .tick(w_tick), .wrap(w_wrap), .done(w_done));

    bcd_counter_4digit #(.TICK_DIV(TD), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3),
        .tick(s_tick), .wrap(s_wrap), .done(s_done));

    assign w_bus = {w_d3, w_d2, w_d1, w_d0};
    assign s_bus = {s_d3, s_d2, s_d1, s_d0};

    function automatic int load_to_int(input logic [15:0] v);
        int r = 0;
        for (int k = 3; k >= 0; k--) begin
            int n = int'(v[k*4 +: 4]);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_step();
        bit due;
        if (rst) begin
            m_vw = 0; m_vs = 0; m_ph = 0; m_tick = 0; m_wrapw = 0; m_done = 0;
        end else if (load) begin
            m_vw = load_to_int(load_val); m_vs = m_vw;
            m_ph = 0; m_tick = 0; m_wrapw = 0; m_done = 0;
        end else if (en) begin
            due     = (m_ph == TD - 1);
            m_ph    = (m_ph + 1) % TD;
            m_tick  = due;
            m_wrapw = 0;
            if (due) begin
                if (up) begin
                    m_wrapw = (m_vw == 9999);
                    m_vw    = (m_vw + 1) % 10000;
                    if (m_vs == 9999) m_done = 1; else m_vs = m_vs + 1;
                end else begin
                    m_wrapw = (m_vw == 0);
                    m_vw    = (m_vw + 9999) % 10000;
                    if (m_vs == 0) m_done = 1; else m_vs = m_vs - 1;
                end
            end
        end else begin
            m_tick = 0; m_wrapw = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("w_digits", {16'd0, w_bus}, {16'd0, int_to_bcd(m_vw)});
        check("w_tick", {31'd0, w_tick}, {31'd0, m_tick});
        check("w_wrap", {31'd0, w_wrap}, {31'd0, m_wrapw});
        check("w_done", {31'd0, w_done}, 32'd0);
        check("s_digits", {16'd0, s_bus}, {16'd0, int_to_bcd(m_vs)});
        check("s_tick", {31'd0, s_tick}, {31'd0, m_tick});
        check("s_wrap", {31'd0, s_wrap}, 32'd0);
        check("s_done", {31'd0, s_done}, {31'd0, m_done});
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [15:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
    endtask

    typedef struct {
        logic [15:0] lv;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];
    int   tick_cnt;
    bit   any_wrap;

    initial begin
        tbl[0] = '{16'h1234, 16'h1234};
        tbl[1] = '{16'hA3F2, 16'h9392};
        tbl[2] = '{16'hFFFF, 16'h9999};
        tbl[3] = '{16'h0000, 16'h0000};
        tbl[4] = '{16'h9A0B, 16'h9909};
        tbl[5] = '{16'h5C7E, 16'h5979};

        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h4321);
        @(posedge clk); model_step(); #1;
        clk_cycle();
        check("reset_digits", {16'd0, w_bus}, 32'd0);
        check("reset_flags", {29'd0, w_tick, s_wrap, s_done}, 32'd0);

        // count up from reset: tick every 4th cycle, 10 ticks reach 0010
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            clk_cycle();
            check("tick_period", {31'd0, w_tick}, {31'd0, (i % 4) == 0});
            if (w_tick) tick_cnt++;
        end
        check("ten_ticks", tick_cnt, 32'd10);
        check("count_0010", {16'd0, w_bus}, 32'h0010);

        // load table with en=0, including invalid BCD nibbles
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, tbl[i].lv);
            clk_cycle();
            check("load_tbl_w", {16'd0, w_bus}, {16'd0, tbl[i].exp});
            check("load_tbl_s", {16'd0, s_bus}, {16'd0, tbl[i].exp});
            check("load_tbl_tick", {31'd0, w_tick}, 32'd0);
        end

        // up wrap 9998 -> 9999 -> 0000
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
        clk_cycle();
        load = 1'b0;
        run(4);
        check("upwrap_9999", {16'd0, w_bus}, 32'h9999);
        run(4);
        check("upwrap_0000", {16'd0, w_bus}, 32'h0000);
        check("upwrap_pulse", {30'd0, w_wrap, w_tick}, 32'd3);
        check("upsat_hold", {16'd0, s_bus}, 32'h9999);
        check("upsat_done", {31'd0, s_done}, 32'd1);
        clk_cycle();
        check("upwrap_one_cycle", {31'd0, w_wrap}, 32'd0);

        // down borrow 1000 -> 0999, then 0000 -> 9999
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1000);
        clk_cycle();
        load = 1'b0;
        run(4);
        check("borrow_0999", {16'd0, w_bus}, 32'h0999);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        clk_cycle();
        load = 1'b0;
        run(4);
        check("downwrap_9999", {16'd0, w_bus}, 32'h9999);
        check("downwrap_pulse", {31'd0, w_wrap}, 32'd1);
        check("downsat_hold", {16'd0, s_bus}, 32'h0000);
        check("downsat_done", {31'd0, s_done}, 32'd1);

        // saturate: three steps at 9999, done sticky, wrap never
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999);
        clk_cycle();
        check("sat_load_clears_done", {31'd0, s_done}, 32'd0);
        load = 1'b0;
        any_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            clk_cycle();
            any_wrap = any_wrap | s_wrap;
        end
        check("sat_hold_9999", {16'd0, s_bus}, 32'h9999);
        check("sat_done_sticky", {31'd0, s_done}, 32'd1);
        check("sat_no_wrap", {31'd0, any_wrap}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
        clk_cycle();
        check("sat_reload_done", {31'd0, s_done}, 32'd0);

        // load colliding with a due step, invalid nibbles clamp
        load = 1'b0;
        run(3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hA3F2);
        clk_cycle();
        check("collide_digits", {16'd0, w_bus}, 32'h9392);
        check("collide_tick", {31'd0, w_tick}, 32'd0);
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            clk_cycle();
            check("collide_restart", {31'd0, w_tick}, {31'd0, i == 4});
        end
        check("collide_next", {16'd0, w_bus}, 32'h9393);

        // pause mid-period keeps phase
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        clk_cycle();
        load = 1'b0;
        run(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_cycle();
            check("pause_frozen", {15'd0, w_tick, w_bus}, 32'h0000);
        end
        en = 1'b1;
        clk_cycle();
        check("resume_no_tick", {31'd0, w_tick}, 32'd0);
        clk_cycle();
        check("resume_tick", {15'd0, w_tick, w_bus}, 32'h10001);

        // reset on a step-due cycle
        run(3);
        rst = 1'b1;
        clk_cycle();
        check("midrst_digits", {15'd0, w_tick, w_bus}, 32'h0);
        rst = 1'b0;
        clk_cycle();
        check("midrst_next_tick", {31'd0, w_tick}, 32'd0);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                  16'($urandom));
            clk_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
